// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared response codes and FSM encodings for the AXI4-Lite slave front end
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_COLLECT_ENC = 2'd0;
    localparam logic [1:0] W_ISSUE_ENC   = 2'd1;
    localparam logic [1:0] W_RESP_ENC    = 2'd2;

    localparam logic [1:0] R_IDLE_ENC  = 2'd0;
    localparam logic [1:0] R_ISSUE_ENC = 2'd1;
    localparam logic [1:0] R_WAIT_ENC  = 2'd2;
    localparam logic [1:0] R_RESP_ENC  = 2'd3;

    typedef enum logic [1:0] {
        W_COLLECT = W_COLLECT_ENC,
        W_ISSUE   = W_ISSUE_ENC,
        W_RESP    = W_RESP_ENC
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = R_IDLE_ENC,
        R_ISSUE = R_ISSUE_ENC,
        R_WAIT  = R_WAIT_ENC,
        R_RESP  = R_RESP_ENC
    } rd_state_t;

    // The register bank decodes every address, so callers always pass err=0.
    function automatic logic [1:0] resp_code(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_wr_fsm.sv
// rtl/axi_lite_wr_fsm.sv - write channel: collects AW and W independently, issues one wr_en, returns B
module axi_lite_wr_fsm
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic                    bvalid,
    input  logic                    bready,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] wr_strb
);

    wr_state_t state;
    logic      aw_held;
    logic      w_held;
    logic      aw_hs;
    logic      w_hs;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // wr_addr/wr_data/wr_strb double as the latches; they are only qualified by wr_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= W_COLLECT;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_strb <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                W_COLLECT: begin
                    if (aw_hs) begin
                        wr_addr <= awaddr;
                        aw_held <= 1'b1;
                        awready <= 1'b0;
                    end else begin
                        awready <= !aw_held;
                    end
                    if (w_hs) begin
                        wr_data <= wdata;
                        wr_strb <= wstrb;
                        w_held  <= 1'b1;
                        wready  <= 1'b0;
                    end else begin
                        wready <= !w_held;
                    end
                    if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                        wr_en <= 1'b1;
                        state <= W_ISSUE;
                    end
                end
                W_ISSUE: begin
                    bvalid <= 1'b1;
                    state  <= W_RESP;
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        state   <= W_COLLECT;
                    end
                end
                default: state <= W_COLLECT;
            endcase
        end
    end

endmodule

// File: rtl/axi_lite_slave_if.sv
// rtl/axi_lite_slave_if.sv - AXI4-Lite slave front end driving the reg_bank write and read ports
module axi_lite_slave_if
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] wr_strb,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    rd_valid
);

    rd_state_t rd_state;
    logic      unused_prot;

    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};
    assign s_axi_bresp = resp_code(1'b0);
    assign s_axi_rresp = resp_code(1'b0);

    axi_lite_wr_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .awaddr  (s_axi_awaddr),
        .awvalid (s_axi_awvalid),
        .awready (s_axi_awready),
        .wdata   (s_axi_wdata),
        .wstrb   (s_axi_wstrb),
        .wvalid  (s_axi_wvalid),
        .wready  (s_axi_wready),
        .bvalid  (s_axi_bvalid),
        .bready  (s_axi_bready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_strb (wr_strb)
    );

    // rd_en is raised on the AR handshake edge so it is high exactly while in R_ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state      <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            rd_en         <= 1'b0;
            rd_addr       <= '0;
        end else begin
            rd_en <= 1'b0;
            case (rd_state)
                R_IDLE: begin
                    if (s_axi_arready && s_axi_arvalid) begin
                        rd_addr       <= s_axi_araddr;
                        s_axi_arready <= 1'b0;
                        rd_en         <= 1'b1;
                        rd_state      <= R_ISSUE;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_ISSUE: rd_state <= R_WAIT;
                R_WAIT: begin
                    if (rd_valid) begin
                        s_axi_rdata  <= rd_data;
                        s_axi_rvalid <= 1'b1;
                        rd_state     <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        rd_state      <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule
